// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
//   Instruction-fetch stage feeding the pipelined decode/execute control block.
//   Holds a small writable instruction memory, runs the program counter and
//   presents one registered 32-bit instruction per cycle. Once the last word
//   has been issued it inserts NOP bubbles so the downstream pipeline drains,
//   then reports completion.
//
//   Parameters
//     IMEM_DEPTH  number of instruction words (addresses 0..IMEM_DEPTH-1)
//     PC_W        width of PC / prog_addr / pc_out / fetch_cnt,
//                 2**PC_W must exceed IMEM_DEPTH
//     DRAIN_CYC   number of NOP bubbles issued after the last instruction
//
//   Ports
//     CLK         clock, rising edge
//     RST         synchronous active-low reset
//     prog_we     instruction memory write enable (IDLE/DONE only)
//     prog_addr   write address, out-of-range addresses are dropped
//     prog_data   instruction word to write
//     start       begin fetching from PC=0 (IDLE/DONE only)
//     stall       decode load-use stall, freezes fetch in RUN
//     inst        registered instruction to decode
//     inst_valid  inst carries a fetched instruction rather than a bubble
//     pc_out      address of the instruction on inst
//     busy        fetch or drain in progress
//     done        program finished and pipeline drained
//     illegal     sticky: an undefined opcode was fetched this run
//     fetch_cnt   instructions issued since start
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | after reset, memory may be programmed, waits for start
//   RUN   | fetching imem[PC] each unstalled cycle
//   DRAIN | issuing DRAIN_CYC bubbles after the last instruction
//   DONE  | completed, outputs hold, memory may be reprogrammed / restarted
// -----------------------------------------------------------------------------
module inst_fetch_unit #(
  parameter int IMEM_DEPTH = 20,
  parameter int PC_W       = 5,
  parameter int DRAIN_CYC  = 3
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            prog_we,
  input  logic [PC_W-1:0] prog_addr,
  input  logic [31:0]     prog_data,
  input  logic            start,
  input  logic            stall,
  output logic [31:0]     inst,
  output logic            inst_valid,
  output logic [PC_W-1:0] pc_out,
  output logic            busy,
  output logic            done,
  output logic            illegal,
  output logic [PC_W-1:0] fetch_cnt
);

  localparam int DCW = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);

  localparam logic [PC_W-1:0] DEPTH_PC   = PC_W'(IMEM_DEPTH);
  localparam logic [PC_W-1:0] LAST_PC    = PC_W'(IMEM_DEPTH - 1);
  localparam logic [DCW-1:0]  DRAIN_LAST = DCW'(DRAIN_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [DCW-1:0]  drain_cnt;
  logic [31:0]     imem [IMEM_DEPTH];
  logic [31:0]     fetch_word;
  logic            prog_ok;

  // Only the documented opcodes are accepted; anything else is replaced by a
  // NOP so decode never sees an undefined encoding.
  function automatic logic opcode_legal(input logic [7:0] op);
    case (op)
      8'h00, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

  assign fetch_word = imem[pc];

  // Memory is writable only while the fetch engine is parked, so a running
  // program can never be modified underneath itself.
  assign prog_ok = RST && prog_we && (prog_addr < DEPTH_PC) &&
                   ((state == S_IDLE) || (state == S_DONE));

  // Instruction memory has no reset: contents survive RST so a program can be
  // rerun after an abort without reloading.
  always_ff @(posedge CLK) begin
    if (prog_ok) begin
      imem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state      <= S_IDLE;
      pc         <= '0;
      drain_cnt  <= '0;
      inst       <= '0;
      inst_valid <= 1'b0;
      pc_out     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      illegal    <= 1'b0;
      fetch_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_RUN;
            pc         <= '0;
            drain_cnt  <= '0;
            inst       <= '0;
            inst_valid <= 1'b0;
            fetch_cnt  <= '0;
            illegal    <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end

        S_RUN: begin
          // A stall simply skips the update, so the current instruction is
          // re-presented unchanged.
          if (!stall) begin
            pc_out     <= pc;
            inst_valid <= 1'b1;
            fetch_cnt  <= fetch_cnt + PC_W'(1);
            if (opcode_legal(fetch_word[31:24])) begin
              inst <= fetch_word;
            end else begin
              inst    <= '0;
              illegal <= 1'b1;
            end
            if (pc == LAST_PC) begin
              state     <= S_DRAIN;
              drain_cnt <= '0;
            end else begin
              pc <= pc + PC_W'(1);
            end
          end
        end

        S_DRAIN: begin
          inst       <= '0;
          inst_valid <= 1'b0;
          drain_cnt  <= drain_cnt + DCW'(1);
          if (drain_cnt == DRAIN_LAST) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

  localparam int DEPTH = 20;
  localparam int PW    = 5;
  localparam int DR    = 3;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          prog_we = 1'b0;
  logic [PW-1:0] prog_addr = '0;
  logic [31:0]   prog_data = '0;
  logic          start = 1'b0;
  logic          stall = 1'b0;
  logic [31:0]   inst;
  logic          inst_valid;
  logic [PW-1:0] pc_out;
  logic          busy;
  logic          done;
  logic          illegal;
  logic [PW-1:0] fetch_cnt;

  inst_fetch_unit #(.IMEM_DEPTH(DEPTH), .PC_W(PW), .DRAIN_CYC(DR)) dut (
    .CLK(CLK), .RST(RST), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .stall(stall), .inst(inst),
    .inst_valid(inst_valid), .pc_out(pc_out), .busy(busy), .done(done),
    .illegal(illegal), .fetch_cnt(fetch_cnt)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Reference model: a program is "running" until every word has been issued
  // and DR bubbles have followed; progress is tracked as counts of words and
  // bubbles issued.
  logic [31:0] m_mem [DEPTH];
  bit          m_run;
  int          m_fetched;
  int          m_bub;
  logic [31:0] m_inst;
  bit          m_valid;
  bit          m_done;
  bit          m_ill;
  int          m_pc;
  int          m_cnt;

  function automatic bit legal(input logic [7:0] op);
    return (op == 8'd0) || (op == 8'd4) || (op == 8'd8) || (op == 8'd16) ||
           (op == 8'd32) || (op == 8'd64) || (op == 8'd128);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [31:0] w;
    if (!RST) begin
      m_run = 0; m_fetched = 0; m_bub = 0; m_inst = '0; m_valid = 0;
      m_done = 0; m_ill = 0; m_pc = 0; m_cnt = 0;
    end else if (!m_run) begin
      if (prog_we && (int'(prog_addr) < DEPTH)) m_mem[prog_addr] = prog_data;
      if (start) begin
        m_run = 1; m_fetched = 0; m_bub = 0; m_ill = 0; m_done = 0;
        m_valid = 0; m_inst = '0; m_cnt = 0;
      end
    end else if (m_fetched < DEPTH) begin
      if (!stall) begin
        w = m_mem[m_fetched];
        if (legal(w[31:24])) m_inst = w;
        else begin
          m_inst = '0;
          m_ill  = 1;
        end
        m_valid = 1;
        m_pc    = m_fetched;
        m_fetched++;
        m_cnt++;
      end
    end else begin
      m_inst  = '0;
      m_valid = 0;
      m_bub++;
      if (m_bub == DR) begin
        m_run  = 0;
        m_done = 1;
      end
    end
  endtask

  task automatic check_outs();
    chk("inst",       inst,              m_inst);
    chk("inst_valid", 32'(inst_valid),   32'(m_valid));
    chk("pc_out",     32'(pc_out),       32'(m_pc));
    chk("busy",       32'(busy),         32'(m_run));
    chk("done",       32'(done),         32'(m_done));
    chk("illegal",    32'(illegal),      32'(m_ill));
    chk("fetch_cnt",  32'(fetch_cnt),    32'(m_cnt));
  endtask

  task automatic cyc(input bit r, input bit we, input logic [PW-1:0] a,
                     input logic [31:0] d, input bit s, input bit st);
    RST = r; prog_we = we; prog_addr = a; prog_data = d; start = s; stall = st;
    @(posedge CLK);
    model_edge();
    #1;
    check_outs();
  endtask

  task automatic idle_cyc();
    cyc(1, 0, '0, '0, 0, 0);
  endtask

  task automatic wait_done(input int stall_at, input int stall_len, input bit wr_run,
                           output int lat);
    int stalled;
    bit st;
    stalled = 0;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      st = m_run && m_valid && (m_pc == stall_at) && (stalled < stall_len);
      if (st) stalled++;
      cyc(1, wr_run, 5'd3, 32'hDEADBEEF, 0, st);
      lat++;
    end
    chk("run_bound", 32'(lat < 100), 32'd1);
  endtask

  task automatic run_prog(input int stall_at, input int stall_len, input bit wr_run,
                          output int lat);
    cyc(1, 0, '0, '0, 1, 0);
    wait_done(stall_at, stall_len, wr_run, lat);
  endtask

  function automatic logic [31:0] rand_word();
    logic [7:0] ops [7];
    logic [7:0] op;
    ops[0] = 8'd0; ops[1] = 8'd4; ops[2] = 8'd8; ops[3] = 8'd16;
    ops[4] = 8'd32; ops[5] = 8'd64; ops[6] = 8'd128;
    if ($urandom_range(7) == 0) op = 8'($urandom);
    else op = ops[$urandom_range(6)];
    return {op, 24'($urandom)};
  endfunction

  initial begin
    int lat;
    int guard;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

    // reset state
    cyc(0, 0, '0, '0, 0, 0);
    cyc(0, 0, '0, '0, 0, 0);
    chk("rst_busy", 32'(busy), 32'd0);

    // load the counting program and run it straight through
    for (int i = 0; i < DEPTH; i++) cyc(1, 1, PW'(i), 32'h2000_0000 | i, 0, 0);
    run_prog(-1, 0, 0, lat);
    chk("latency_nostall", 32'(lat), 32'd23);
    chk("fetch_cnt_done", 32'(fetch_cnt), 32'd20);

    // two-cycle stall while pc_out=5
    run_prog(5, 2, 0, lat);
    chk("latency_stall2", 32'(lat), 32'd25);

    // illegal opcode at address 7, sticky until the next start
    cyc(1, 1, 5'd7, 32'hFF01_0203, 0, 0);
    run_prog(-1, 0, 0, lat);
    chk("illegal_at_done", 32'(illegal), 32'd1);
    cyc(1, 1, 5'd7, 32'h2000_0007, 1, 0);
    chk("illegal_cleared", 32'(illegal), 32'd0);
    wait_done(-1, 0, 0, lat);

    // writes during RUN and to an out-of-range address are dropped
    run_prog(-1, 0, 1, lat);
    cyc(0, 0, '0, '0, 0, 0);
    cyc(1, 1, 5'd25, 32'hDEAD_0000, 0, 0);
    run_prog(-1, 0, 0, lat);
    chk("imem3_intact", m_mem[3], 32'h2000_0003);

    // reset at pc_out=10 aborts, memory survives
    cyc(1, 0, '0, '0, 1, 0);
    guard = 0;
    while (!(m_valid && m_pc == 10) && guard < 50) begin
      idle_cyc();
      guard++;
    end
    chk("reach_pc10", 32'(guard < 50), 32'd1);
    cyc(0, 0, '0, '0, 0, 0);
    chk("abort_busy", 32'(busy), 32'd0);
    run_prog(-1, 0, 0, lat);
    chk("latency_after_abort", 32'(lat), 32'd23);

    // same-edge write and start from DONE
    cyc(1, 1, 5'd0, 32'h1000_0102, 1, 0);
    idle_cyc();
    chk("first_inst_new", inst, 32'h1000_0102);
    chk("first_pc", 32'(pc_out), 32'd0);
    wait_done(-1, 0, 0, lat);

    // randomized traffic: programs, stalls, stray starts/writes, rare resets
    for (int i = 0; i < DEPTH; i++) cyc(1, 1, PW'(i), rand_word(), 0, 0);
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(80) != 0), ($urandom_range(3) == 0), PW'($urandom_range(31)),
          rand_word(), ($urandom_range(7) == 0), ($urandom_range(2) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
